imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction BRAM read path.
- Consumes a byte stream, normally from the UART receiver, framed as: 4-byte little-endian word count N, then N little-endian instruction words, then a 4-byte little-endian checksum.
- Writes each word into the instruction memory write port at the byte address the fetch stage will later present.
- Holds the core in reset until the image is loaded and the checksum passes.

Parameters:
- MEM_WORDS, 32000, instruction memory depth in 32-bit words; a header with N > MEM_WORDS is rejected.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-aligned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- wr_en  output  1  instruction memory write strobe, single cycle.
- wr_addr  output  32  byte address; the memory indexes by wr_addr>>2.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  keeps the core in reset while high.
- done  output  1  load succeeded, sticky.
- err  output  1  load failed, sticky.
- word_cnt  output  32  number of words written so far.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
  - While rst is high: state=LEN, byte index=0, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0, word_cnt=0, checksum accumulator=0.
  - in_ready goes high on the first clock after rst deasserts.
- Byte acceptance:
  - A byte is accepted on a rising edge with in_valid && in_ready.
  - A 2-bit byte index selects the lane: byte k goes to bits [8k+7:8k], little-endian.
  - The index wraps 3->0 on each 4th accepted byte.
- States:
  - LEN: collect 4 bytes into N.
    - On the 4th byte: N==0 -> CSUM; N>MEM_WORDS -> ERR; otherwise -> DATA.
  - DATA: on the 4th byte of a word, wr_en=1 for exactly the next cycle.
    - In that cycle: wr_data = the assembled word, wr_addr = BASE_ADDR + 4*word_cnt (pre-increment value).
    - word_cnt increments in the same cycle wr_en is high.
    - checksum = checksum + word, modulo 2^32.
    - When the word just written is word N-1 -> CSUM.
  - CSUM: collect 4 bytes.
    - On the 4th byte: match -> DONE, mismatch -> ERR.
    - done or err is asserted on the next cycle.
  - DONE: in_ready=0, cpu_hold=0, done=1. The block remains here until rst.
  - ERR: in_ready=0, cpu_hold=1, err=1. The block remains here until rst.
- Throughput: in_ready stays 1 in LEN, DATA and CSUM, so back-to-back bytes are accepted every cycle.
- Gaps: in_valid gaps of any length are tolerated; partial words are retained across them.
- wr_en never asserts outside DATA and is never high for two consecutive cycles.
- done and err are mutually exclusive. cpu_hold = !done at all times.
- wr_addr carries exactly 32 bits; there is no overflow check beyond the N<=MEM_WORDS limit.
- rst mid-load returns the block to the LEN state and clears all counters. Words already written to memory are not scrubbed.
- Bytes arriving while in DONE or ERR are not accepted (in_ready=0).

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding (LEN, DATA, CSUM, DONE, ERR);
  - the header and checksum byte-count constant (4);
  - the default MEM_WORDS value, shared with the instruction memory.
- One sub-module is natural: byte_packer.
  - 8-to-32 little-endian assembler with a 2-bit lane counter and a word_valid pulse.
  - It is reused by LEN, DATA and CSUM.
- The FSM, address/count logic and checksum stay in imem_loader.

Test Plan:
- Case 1, basic load:
  - Stimulus: N=2, words 32'h00000093 and 32'h00100113, checksum 32'h001001A6, back-to-back bytes.
  - Required: wr_en pulses with (0x0, 0x00000093) then (0x4, 0x00100113); done=1 one cycle after the last checksum byte; cpu_hold falls in the same cycle; word_cnt=2.
- Case 2, bad checksum:
  - Stimulus: same image with checksum 32'h00000000.
  - Required: both writes occur; err=1, done=0, cpu_hold stays 1, in_ready=0 afterwards.
- Case 3, oversize header:
  - Stimulus: N=MEM_WORDS+1.
  - Required: err=1 after the 4th header byte; no wr_en pulse ever.
- Case 4, empty image:
  - Stimulus: N=0, checksum 0.
  - Required: done=1; no writes; word_cnt=0.
- Case 5, stalled stream:
  - Stimulus: case 1 with 0 to 7 random idle cycles between bytes, and BASE_ADDR=32'h100.
  - Required: identical data, with write addresses 0x100 and 0x104.
- Case 6, reset mid-load:
  - Stimulus: assert rst after the 2nd byte of word 1, then replay case 1 in full.
  - Required: every output returns to its reset value immediately; the replay completes with done=1 and word_cnt=2.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: state encoding,
// framing constants and the default memory depth (also used by the imem).
package loader_pkg;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_e;

  // Header word count and trailing checksum are both one 32-bit word.
  localparam int unsigned HDR_BYTES = 4;

  localparam int unsigned DEFAULT_MEM_WORDS = 32000;

  // Byte address of instruction word idx when word 0 lives at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port and status of the
// loader. slave = loader view, master = stream source / memory / monitor view.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [31:0] word_cnt;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, word_cnt
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, word_cnt
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8-to-32 little-endian assembler. word_valid_o is combinational and fires in
// the cycle the 4th byte is accepted, with word_o already holding that byte in
// the top lane, so the caller can register the full word on the same edge.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LANE_LAST = 2'(HDR_BYTES - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] part_q, part_d;

  // Steer each accepted byte into its lane; the lane counter wraps 3->0.
  always_comb begin
    lane_d       = lane_q;
    part_d       = part_q;
    word_valid_o = byte_valid_i && (lane_q == LANE_LAST);
    word_o       = {byte_data_i, part_q};
    if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    part_d[7:0]   = byte_data_i;
        2'd1:    part_d[15:8]  = byte_data_i;
        2'd2:    part_d[23:16] = byte_data_i;
        default: part_d        = '0;
      endcase
    end
  end

  // Lane counter and partial word survive input gaps untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      part_q <= '0;
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed image (count, words, checksum) from a byte stream into the
// instruction memory and releases the core only after a good checksum.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LEN   | collecting the 4-byte word count N
//   DATA  | collecting instruction words, one memory write per word
//   CSUM  | collecting the 4-byte checksum, compared on the last byte
//   DONE  | image accepted, core released; sticky until rst
//   ERR   | oversize header or bad checksum, core held; sticky until rst
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  loader_state_e state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic [31:0]   csum_q, csum_d;
  logic [31:0]   len_q, len_d;

  logic          accept;
  logic          word_valid;
  logic [31:0]   word;

  assign accept = bus.in_valid && in_ready_q;

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (accept),
    .byte_data_i  (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next state and registered outputs; every output is a flop so done/err and
  // the write strobe appear the cycle after the deciding byte.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    len_d      = len_q;

    case (state_q)
      LEN: begin
        if (word_valid) begin
          len_d = word;
          if (word == 32'd0)                 state_d = CSUM;
          else if (word > 32'(MEM_WORDS))    state_d = ERR;
          else                               state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) begin
          wr_en_d    = 1'b1;
          wr_data_d  = word;
          wr_addr_d  = word_addr(BASE_ADDR, word_cnt_q);
          word_cnt_d = word_cnt_q + 32'd1;
          csum_d     = csum_q + word;
          if (word_cnt_q + 32'd1 == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (word_valid) state_d = (word == csum_q) ? DONE : ERR;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    in_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  // State and output registers; rst mid-load restarts framing from LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cpu_hold = !done_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Two loaders (base 0x0 and base 0x100) receive the same byte stream; each
// image vector is replayed against both and their writes/status compared.
module tb_imem_loader;
  import loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;

  imem_loader #(.MEM_WORDS(32000), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  imem_loader #(.MEM_WORDS(32000), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));

  // Write capture and per-cycle invariants.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int   viol = 0;
  logic pa = 1'b0, pb = 1'b0;

  always @(negedge clk) begin
    if (ifa.wr_en) qa.push_back({ifa.wr_addr, ifa.wr_data});
    if (ifb.wr_en) qb.push_back({ifb.wr_addr, ifb.wr_data});
    if ((ifa.wr_en && pa) || (ifb.wr_en && pb) ||
        (ifa.done && ifa.err) || (ifb.done && ifb.err) ||
        (ifa.cpu_hold == ifa.done) || (ifb.cpu_hold == ifb.done))
      viol <= viol + 1;
    pa <= ifa.wr_en;
    pb <= ifb.wr_en;
  end

  typedef struct {
    string       name;
    logic [31:0] n;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] csum;
    bit          send_csum;
    bit          stall;
    bit          exp_done;
    bit          exp_err;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(string name, logic [31:0] n, int nw,
                              logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] csum, bit send_csum, bit stall,
                              bit exp_done, bit exp_err, logic [31:0] exp_cnt);
    vec_t v;
    v.name = name; v.n = n; v.nw = nw; v.w0 = w0; v.w1 = w1; v.csum = csum;
    v.send_csum = send_csum; v.stall = stall; v.exp_done = exp_done;
    v.exp_err = exp_err; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a.in_ready"}, 32'(ifa.in_ready), 32'd0);
    chk({tag, " a.wr_en"},    32'(ifa.wr_en),    32'd0);
    chk({tag, " a.wr_addr"},  ifa.wr_addr,       32'h0);
    chk({tag, " a.wr_data"},  ifa.wr_data,       32'h0);
    chk({tag, " a.cpu_hold"}, 32'(ifa.cpu_hold), 32'd1);
    chk({tag, " a.done"},     32'(ifa.done),     32'd0);
    chk({tag, " a.err"},      32'(ifa.err),      32'd0);
    chk({tag, " a.word_cnt"}, ifa.word_cnt,      32'd0);
    chk({tag, " b.wr_addr"},  ifb.wr_addr,       32'h100);
    chk({tag, " b.wr_data"},  ifb.wr_data,       32'h0);
    chk({tag, " b.word_cnt"}, ifb.word_cnt,      32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " in_ready after rst"}, 32'(ifa.in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) repeat ($urandom_range(0, 7)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!ifa.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  bs[$];
    logic [31:0] w;
    int          sa, sb;
    logic [31:0] ew;
    sa = qa.size();
    sb = qb.size();
    for (int k = 0; k < 4; k++) bs.push_back(v.n[8*k +: 8]);
    for (int i = 0; i < v.nw; i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      for (int k = 0; k < 4; k++) bs.push_back(w[8*k +: 8]);
    end
    if (v.send_csum)
      for (int k = 0; k < 4; k++) bs.push_back(v.csum[8*k +: 8]);

    for (int i = 0; i < bs.size(); i++) begin
      if (i == bs.size() - 1) begin
        chk({v.name, " done before last byte"}, 32'(ifa.done), 32'd0);
        chk({v.name, " err before last byte"},  32'(ifa.err),  32'd0);
      end
      send_byte(bs[i], v.stall);
    end
    // One cycle after the deciding byte.
    chk({v.name, " a.done next cycle"},     32'(ifa.done),     32'(v.exp_done));
    chk({v.name, " a.err next cycle"},      32'(ifa.err),      32'(v.exp_err));
    chk({v.name, " a.cpu_hold next cycle"}, 32'(ifa.cpu_hold), 32'(!v.exp_done));
    chk({v.name, " b.done next cycle"},     32'(ifb.done),     32'(v.exp_done));
    chk({v.name, " b.err next cycle"},      32'(ifb.err),      32'(v.exp_err));

    repeat (3) @(negedge clk);
    chk({v.name, " a.done final"},     32'(ifa.done),     32'(v.exp_done));
    chk({v.name, " a.err final"},      32'(ifa.err),      32'(v.exp_err));
    chk({v.name, " a.cpu_hold final"}, 32'(ifa.cpu_hold), 32'(!v.exp_done));
    chk({v.name, " a.in_ready final"}, 32'(ifa.in_ready), 32'd0);
    chk({v.name, " a.word_cnt"},       ifa.word_cnt,      v.exp_cnt);
    chk({v.name, " b.word_cnt"},       ifb.word_cnt,      v.exp_cnt);
    chk({v.name, " a.nwrites"}, 32'(qa.size() - sa), 32'(v.nw));
    chk({v.name, " b.nwrites"}, 32'(qb.size() - sb), 32'(v.nw));
    for (int i = 0; i < v.nw; i++) begin
      ew = (i == 0) ? v.w0 : v.w1;
      if (sa + i < qa.size())
        chk({v.name, " a.write"}, qa[sa+i][63:32], 32'(4*i));
      if (sa + i < qa.size())
        chk({v.name, " a.wdata"}, qa[sa+i][31:0], ew);
      if (sb + i < qb.size())
        chk({v.name, " b.write"}, qb[sb+i][63:32], 32'h100 + 32'(4*i));
      if (sb + i < qb.size())
        chk({v.name, " b.wdata"}, qb[sb+i][31:0], ew);
    end
  endtask

  initial begin
    vecs[0] = mk("basic",    32'd2,     2, 32'h00000093, 32'h00100113,
                 32'h001001A6, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2);
    vecs[1] = mk("bad_csum", 32'd2,     2, 32'h00000093, 32'h00100113,
                 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2);
    vecs[2] = mk("oversize", 32'd32001, 0, 32'h0, 32'h0,
                 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    vecs[3] = mk("empty",    32'd0,     0, 32'h0, 32'h0,
                 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    vecs[4] = mk("stalled",  32'd2,     2, 32'h00000093, 32'h00100113,
                 32'h001001A6, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2);
    vecs[5] = mk("one_word", 32'd1,     1, 32'hDEADBEEF, 32'h0,
                 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_reset({vecs[i].name, " reset"});
      run_vec(vecs[i]);
    end

    // Reset mid-load: header, word 0, two bytes of word 1, then rst.
    do_reset("midload reset");
    begin
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = 32'h00000093;
      w1 = 32'h00100113;
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b0);
      send_byte(w1[7:0], 1'b0);
      send_byte(w1[15:8], 1'b0);
      chk("midload word_cnt before rst", ifa.word_cnt, 32'd1);
      chk("midload wr_data before rst",  ifa.wr_data,  32'h00000093);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_vals("midload async");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_vec(vecs[0]);
    end

    chk("wr_en b2b / done-err / cpu_hold invariants", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
